// File: rtl/exe_stage_if.sv
// ID->EXE payload, EXE<->ALU operand/result path and EXE->MEM handoff.
// slave = the EXE stage itself, master = surrounding pipeline/ALU.
interface exe_stage_if #(
    parameter int ALU_OP_W = 19
);
    logic                ds_to_es_valid;
    logic                es_allowin;
    logic [ALU_OP_W-1:0] ds_alu_op;
    logic [31:0]         ds_alu_src1;
    logic [31:0]         ds_alu_src2;
    logic [4:0]          ds_dest;
    logic                ds_gr_we;
    logic                ds_res_from_mem;
    logic [31:0]         ds_pc;

    logic [ALU_OP_W-1:0] es_alu_op;
    logic [31:0]         es_alu_src1;
    logic [31:0]         es_alu_src2;
    logic                es_valid;
    logic [31:0]         alu_result;
    logic                is_div;
    logic                div_finish;

    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [31:0]         es_to_ms_result;
    logic [4:0]          es_to_ms_dest;
    logic                es_to_ms_gr_we;
    logic                es_to_ms_res_from_mem;
    logic [31:0]         es_to_ms_pc;

    logic                es_fwd_valid;
    logic [4:0]          es_fwd_dest;
    logic                es_fwd_block;
    logic                div_timeout;

    modport slave (
        input  ds_to_es_valid, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest,
               ds_gr_we, ds_res_from_mem, ds_pc, alu_result, is_div, div_finish,
               ms_allowin,
        output es_allowin, es_alu_op, es_alu_src1, es_alu_src2, es_valid,
               es_to_ms_valid, es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
               es_to_ms_res_from_mem, es_to_ms_pc, es_fwd_valid, es_fwd_dest,
               es_fwd_block, div_timeout
    );

    modport master (
        output ds_to_es_valid, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest,
               ds_gr_we, ds_res_from_mem, ds_pc, alu_result, is_div, div_finish,
               ms_allowin,
        input  es_allowin, es_alu_op, es_alu_src1, es_alu_src2, es_valid,
               es_to_ms_valid, es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
               es_to_ms_res_from_mem, es_to_ms_pc, es_fwd_valid, es_fwd_dest,
               es_fwd_block, div_timeout
    );
endinterface

// File: rtl/exe_stage.sv
// EXE pipeline stage: payload register, divide stall/hold FSM and MEM handoff.
// A divide result seen on the one-cycle div_finish pulse is captured if MEM stalls.
module exe_stage #(
    parameter int ALU_OP_W    = 19,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    exe_stage_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_HELD} div_state_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [4:0]          dest;
        logic                gr_we;
        logic                res_from_mem;
        logic [31:0]         pc;
    } es_payload_t;

    div_state_e  state_q, state_d;
    es_payload_t pay_q, pay_d;
    logic        es_valid_q, es_valid_d;
    logic [31:0] div_res_q, div_res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic es_ready_go;
    logic es_allowin;
    logic load;
    logic load_div;

    assign es_ready_go = ~bus.is_div | (state_q == DIV_HELD)
                       | ((state_q == DIV_BUSY) & bus.div_finish);
    assign es_allowin  = ~es_valid_q | (es_ready_go & bus.ms_allowin);
    assign load        = bus.ds_to_es_valid & es_allowin;
    assign load_div    = load & (|bus.ds_alu_op[18:15]);

    always_comb begin
        state_d    = state_q;
        pay_d      = pay_q;
        es_valid_d = es_valid_q;
        div_res_d  = div_res_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;

        if (es_allowin) es_valid_d = bus.ds_to_es_valid;
        if (load) begin
            pay_d.alu_op       = bus.ds_alu_op;
            pay_d.src1         = bus.ds_alu_src1;
            pay_d.src2         = bus.ds_alu_src2;
            pay_d.dest         = bus.ds_dest;
            pay_d.gr_we        = bus.ds_gr_we;
            pay_d.res_from_mem = bus.ds_res_from_mem;
            pay_d.pc           = bus.ds_pc;
        end

        // A new divide may load in the same cycle the old one leaves.
        case (state_q)
            DIV_IDLE: if (load_div) state_d = DIV_BUSY;
            DIV_BUSY: begin
                if (bus.div_finish) begin
                    if (bus.ms_allowin) begin
                        state_d = load_div ? DIV_BUSY : DIV_IDLE;
                    end else begin
                        div_res_d = bus.alu_result;
                        state_d   = DIV_HELD;
                    end
                end
            end
            DIV_HELD: if (bus.ms_allowin) state_d = load_div ? DIV_BUSY : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        // Counts stalled BUSY cycles; saturates so the sticky flag never re-arms.
        if ((state_q == DIV_BUSY) && !bus.div_finish) begin
            if (cnt_q != CNT_W'(DIV_TIMEOUT)) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(DIV_TIMEOUT)) timeout_d = 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            pay_q      <= '0;
            es_valid_q <= 1'b0;
            div_res_q  <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pay_q      <= pay_d;
            es_valid_q <= es_valid_d;
            div_res_q  <= div_res_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.es_allowin            = es_allowin;
    assign bus.es_alu_op             = pay_q.alu_op;
    assign bus.es_alu_src1           = pay_q.src1;
    assign bus.es_alu_src2           = pay_q.src2;
    assign bus.es_valid              = es_valid_q;
    assign bus.es_to_ms_valid        = es_valid_q & es_ready_go;
    assign bus.es_to_ms_result       = (state_q == DIV_HELD) ? div_res_q : bus.alu_result;
    assign bus.es_to_ms_dest         = pay_q.dest;
    assign bus.es_to_ms_gr_we        = pay_q.gr_we;
    assign bus.es_to_ms_res_from_mem = pay_q.res_from_mem;
    assign bus.es_to_ms_pc           = pay_q.pc;
    assign bus.es_fwd_valid          = es_valid_q & pay_q.gr_we & (pay_q.dest != 5'd0);
    assign bus.es_fwd_dest           = pay_q.dest;
    assign bus.es_fwd_block          = es_valid_q & (pay_q.res_from_mem | (bus.is_div & ~es_ready_go));
    assign bus.div_timeout           = timeout_q;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table, directed divide/reset/timeout
// sequences, and a randomized run scored against an in-order transaction queue.
module tb_exe_stage;
    localparam logic [18:0] OP_ADD  = 19'h00001;
    localparam logic [18:0] OP_SUB  = 19'h00002;
    localparam logic [18:0] OP_AND  = 19'h00004;
    localparam logic [18:0] OP_OR   = 19'h00008;
    localparam logic [18:0] OP_XOR  = 19'h00010;
    localparam logic [18:0] OP_DIV  = 19'h08000;
    localparam logic [18:0] OP_DIVU = 19'h10000;
    localparam logic [18:0] OP_MOD  = 19'h20000;
    localparam logic [18:0] OP_MODU = 19'h40000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_stage_if #(.ALU_OP_W(19)) bus ();
    exe_stage #(.ALU_OP_W(19), .DIV_TIMEOUT(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] ref_alu(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_DIV:  return 32'($signed(a) / $signed(b));
            OP_DIVU: return a / b;
            OP_MOD:  return 32'($signed(a) % $signed(b));
            OP_MODU: return a % b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU model: a divider's output is only meaningful on its finish pulse.
    always_comb begin
        logic d;
        d = |bus.es_alu_op[18:15];
        bus.is_div = d;
        if (d && !bus.div_finish) bus.alu_result = 32'hDEAD_BEEF;
        else bus.alu_result = ref_alu(bus.es_alu_op, bus.es_alu_src1, bus.es_alu_src2);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ds(input logic v, input logic [18:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, input logic we, input logic rfm, input logic [31:0] pc);
        bus.ds_to_es_valid  = v;
        bus.ds_alu_op       = op;
        bus.ds_alu_src1     = a;
        bus.ds_alu_src2     = b;
        bus.ds_dest         = dest;
        bus.ds_gr_we        = we;
        bus.ds_res_from_mem = rfm;
        bus.ds_pc           = pc;
    endtask

    typedef struct {
        logic [18:0] op;
        logic [31:0] a, b;
        logic [4:0]  dest;
        logic        we, rfm;
        logic [31:0] exp_res;
        logic        exp_fv, exp_blk;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        we, rfm;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    bit          div_busy;
    int          div_left;
    logic [31:0] rpc;
    logic [18:0] ops [9];

    // One randomized cycle: score handoffs, record accepts, drive divider and new inputs.
    task automatic rand_cycle(input bit gen);
        bit   acc;
        exp_t e, g;
        @(negedge clk);
        if (bus.es_to_ms_valid && bus.ms_allowin) begin
            if (sb.size() == 0) begin
                chk("rand_unexpected_handoff", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rand_result", bus.es_to_ms_result, e.res);
                chk("rand_meta", {bus.es_to_ms_dest, bus.es_to_ms_gr_we, bus.es_to_ms_res_from_mem, bus.es_to_ms_pc[24:0]},
                                 {e.dest, e.we, e.rfm, e.pc[24:0]});
            end
        end
        acc = bus.ds_to_es_valid && bus.es_allowin;
        if (acc) begin
            g.res  = ref_alu(bus.ds_alu_op, bus.ds_alu_src1, bus.ds_alu_src2);
            g.dest = bus.ds_dest;
            g.we   = bus.ds_gr_we;
            g.rfm  = bus.ds_res_from_mem;
            g.pc   = bus.ds_pc;
            sb.push_back(g);
        end
        if (bus.div_finish) div_busy = 1'b0;
        if (acc && (|bus.ds_alu_op[18:15])) begin
            div_busy = 1'b1;
            div_left = $urandom_range(0, 5);
        end
        nxt();
        if (!gen) begin
            if (acc) bus.ds_to_es_valid = 1'b0;
        end else if (!bus.ds_to_es_valid || acc) begin
            logic [18:0] op;
            op  = ops[$urandom_range(0, 8)];
            rpc = rpc + 32'd4;
            set_ds(($urandom % 10) < 7, op, $urandom,
                   (|op[18:15]) ? 32'($urandom_range(1, 5000)) : $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), rpc);
        end
        bus.ms_allowin = ($urandom % 10) < 6;
        if (div_busy) begin
            bus.div_finish = (div_left == 0);
            if (div_left != 0) div_left--;
        end else begin
            bus.div_finish = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        vec_t v;
        vecs[0] = '{OP_ADD, 32'd5,          32'd7,          5'd3,  1'b1, 1'b0, 32'd12,         1'b1, 1'b0};
        vecs[1] = '{OP_SUB, 32'd10,         32'd3,          5'd0,  1'b1, 1'b0, 32'd7,          1'b0, 1'b0};
        vecs[2] = '{OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  5'd9,  1'b0, 1'b0, 32'h0000_F000,  1'b0, 1'b0};
        vecs[3] = '{OP_OR,  32'h0000_000F,  32'h0000_00F0,  5'd31, 1'b1, 1'b0, 32'h0000_00FF,  1'b1, 1'b0};
        vecs[4] = '{OP_XOR, 32'hFFFF_FFFF,  32'h0000_0001,  5'd2,  1'b1, 1'b0, 32'hFFFF_FFFE,  1'b1, 1'b0};
        vecs[5] = '{OP_ADD, 32'h0000_1000,  32'h0000_0010,  5'd4,  1'b1, 1'b1, 32'h0000_1010,  1'b1, 1'b1};
        vecs[6] = '{OP_ADD, 32'hFFFF_FFFF,  32'h0000_0001,  5'd0,  1'b1, 1'b1, 32'h0000_0000,  1'b0, 1'b1};
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DIV, OP_DIVU, OP_MOD, OP_MODU};

        set_ds(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
        bus.ms_allowin = 1'b1;
        bus.div_finish = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_es_valid", 32'(bus.es_valid), 32'd0);
        chk("rst_allowin", 32'(bus.es_allowin), 32'd1);
        chk("rst_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd0);
        chk("rst_alu_op", 32'(bus.es_alu_op), 32'd0);
        chk("rst_src1", bus.es_alu_src1, 32'd0);
        chk("rst_timeout", 32'(bus.div_timeout), 32'd0);
        chk("rst_fwd_valid", 32'(bus.es_fwd_valid), 32'd0);

        // Table: one single-cycle op per cycle, each handed off the cycle after load.
        for (int i = 0; i <= 7; i++) begin
            nxt();
            if (i < 7) set_ds(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].we, vecs[i].rfm, 32'h100 + 32'(i * 4));
            else bus.ds_to_es_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                v = vecs[i-1];
                chk("tbl_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd1);
                chk("tbl_result", bus.es_to_ms_result, v.exp_res);
                chk("tbl_dest", 32'(bus.es_to_ms_dest), 32'(v.dest));
                chk("tbl_pc", bus.es_to_ms_pc, 32'h100 + 32'((i - 1) * 4));
                chk("tbl_fwd_valid", 32'(bus.es_fwd_valid), 32'(v.exp_fv));
                chk("tbl_fwd_dest", 32'(bus.es_fwd_dest), 32'(v.dest));
                chk("tbl_fwd_block", 32'(bus.es_fwd_block), 32'(v.exp_blk));
                chk("tbl_allowin", 32'(bus.es_allowin), 32'd1);
            end
        end

        // div 100/7: ten stalled cycles, then handoff on the pulse.
        nxt();
        set_ds(1'b1, OP_DIV, 32'd100, 32'd7, 5'd5, 1'b1, 1'b0, 32'h200);
        nxt();
        bus.ds_to_es_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("div_stall_allowin", 32'(bus.es_allowin), 32'd0);
            chk("div_stall_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
            if (k == 0) chk("div_fwd_block", 32'(bus.es_fwd_block), 32'd1);
            nxt();
        end
        bus.div_finish = 1'b1;
        @(negedge clk);
        chk("div_done_valid", 32'(bus.es_to_ms_valid), 32'd1);
        chk("div_done_result", bus.es_to_ms_result, 32'd14);
        chk("div_done_allowin", 32'(bus.es_allowin), 32'd1);
        nxt();
        bus.div_finish = 1'b0;
        @(negedge clk);
        chk("div_after_valid", 32'(bus.es_valid), 32'd0);

        // modu 100%7 finishing while MEM stalls: held result must survive.
        nxt();
        set_ds(1'b1, OP_MODU, 32'd100, 32'd7, 5'd6, 1'b1, 1'b0, 32'h300);
        bus.ms_allowin = 1'b0;
        nxt();
        bus.ds_to_es_valid = 1'b0;
        nxt();
        bus.div_finish = 1'b1;
        @(negedge clk);
        chk("modu_pulse_result", bus.es_to_ms_result, 32'd2);
        nxt();
        bus.div_finish = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("modu_held_valid", 32'(bus.es_to_ms_valid), 32'd1);
            chk("modu_held_result", bus.es_to_ms_result, 32'd2);
            chk("modu_held_allowin", 32'(bus.es_allowin), 32'd0);
            nxt();
        end
        bus.ms_allowin = 1'b1;
        @(negedge clk);
        chk("modu_release_result", bus.es_to_ms_result, 32'd2);
        chk("modu_release_allowin", 32'(bus.es_allowin), 32'd1);
        nxt();
        @(negedge clk);
        chk("modu_after_valid", 32'(bus.es_valid), 32'd0);

        // div followed by a waiting add: add loads on the pulse, no bubble.
        nxt();
        set_ds(1'b1, OP_DIV, 32'd100, 32'd7, 5'd7, 1'b1, 1'b0, 32'h400);
        nxt();
        set_ds(1'b1, OP_ADD, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0, 32'h404);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_stall_allowin", 32'(bus.es_allowin), 32'd0);
            nxt();
        end
        bus.div_finish = 1'b1;
        @(negedge clk);
        chk("b2b_div_result", bus.es_to_ms_result, 32'd14);
        chk("b2b_div_allowin", 32'(bus.es_allowin), 32'd1);
        nxt();
        bus.div_finish = 1'b0;
        bus.ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("b2b_add_valid", 32'(bus.es_to_ms_valid), 32'd1);
        chk("b2b_add_result", bus.es_to_ms_result, 32'd12);
        chk("b2b_add_pc", bus.es_to_ms_pc, 32'h404);

        // Reset in the fifth BUSY cycle, then a stale finish pulse.
        nxt();
        set_ds(1'b1, OP_DIV, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0, 32'h500);
        nxt();
        bus.ds_to_es_valid = 1'b0;
        repeat (4) nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        bus.div_finish = 1'b1;
        @(negedge clk);
        chk("rstdiv_es_valid", 32'(bus.es_valid), 32'd0);
        chk("rstdiv_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
        chk("rstdiv_allowin", 32'(bus.es_allowin), 32'd1);
        nxt();
        bus.div_finish = 1'b0;
        @(negedge clk);
        chk("rstdiv_after_valid", 32'(bus.es_valid), 32'd0);

        // Randomized traffic against the in-order scoreboard.
        rpc = 32'h1_0000;
        div_busy = 1'b0;
        div_left = 0;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 300; c++) begin
            if (sb.size() == 0 && !bus.es_valid && !bus.ds_to_es_valid) break;
            rand_cycle(1'b0);
        end
        chk("rand_drained", 32'(sb.size() == 0 && !bus.es_valid), 32'd1);

        // Timeout: flag rises exactly after 64 stalled BUSY cycles and is sticky.
        nxt();
        bus.div_finish = 1'b0;
        bus.ms_allowin = 1'b1;
        set_ds(1'b1, OP_DIVU, 32'd9, 32'd3, 5'd1, 1'b1, 1'b0, 32'h600);
        nxt();
        bus.ds_to_es_valid = 1'b0;
        repeat (63) nxt();
        @(negedge clk);
        chk("timeout_63", 32'(bus.div_timeout), 32'd0);
        nxt();
        @(negedge clk);
        chk("timeout_64", 32'(bus.div_timeout), 32'd1);
        nxt();
        bus.div_finish = 1'b1;
        @(negedge clk);
        chk("timeout_late_result", bus.es_to_ms_result, 32'd3);
        nxt();
        bus.div_finish = 1'b0;
        @(negedge clk);
        chk("timeout_sticky", 32'(bus.div_timeout), 32'd1);
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("timeout_cleared", 32'(bus.div_timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
